// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass and a busy-bit scoreboard
// that stalls issue on RAW/WAW hazards against in-flight destinations.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  input  logic             rs1_re,
  input  logic             rs2_re,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             issue_valid,
  input  logic             issue_rd_we,
  input  logic [AW-1:0]    issue_rd,
  output logic             stall,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_we,
  input  logic [XLEN-1:0]  rd_data_from_wb,
  output logic [(1<<AW)-1:0] busy
);

  localparam int unsigned NREGS = 1 << AW;
  localparam bit          FWD   = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_next;
  logic             wb_en;
  logic             fwd1;
  logic             fwd2;
  logic             fwdw;
  logic             hz1;
  logic             hz2;
  logic             hzw;
  logic             issue_fire;

  // Write-back qualifiers: x0 is never written, forwarding only when enabled
  assign wb_en = rd_we && (rd_addr != '0);
  assign fwd1  = FWD && rd_we && (rd_addr == rs1_addr);
  assign fwd2  = FWD && rd_we && (rd_addr == rs2_addr);
  assign fwdw  = FWD && rd_we && (rd_addr == issue_rd);

  // Read port 1: disabled or x0 read as zero, otherwise bypass or array
  always_comb begin
    rs1_data = '0;
    if (rs1_re && (rs1_addr != '0)) begin
      if (fwd1) rs1_data = rd_data_from_wb;
      else      rs1_data = regs[rs1_addr];
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rs2_data = '0;
    if (rs2_re && (rs2_addr != '0)) begin
      if (fwd2) rs2_data = rd_data_from_wb;
      else      rs2_data = regs[rs2_addr];
    end
  end

  // Hazard detection; a same-cycle write-back resolves the hazard when forwarded
  always_comb begin
    hz1        = rs1_re && (rs1_addr != '0) && busy[rs1_addr] && !fwd1;
    hz2        = rs2_re && (rs2_addr != '0) && busy[rs2_addr] && !fwd2;
    hzw        = issue_rd_we && (issue_rd != '0) && busy[issue_rd] && !fwdw;
    stall      = issue_valid && (hz1 || hz2 || hzw);
    issue_fire = issue_valid && !stall && issue_rd_we && (issue_rd != '0);
  end

  // Scoreboard next state: write-back clears, accepted issue sets (set wins)
  always_comb begin
    busy_next = busy;
    if (wb_en)      busy_next[rd_addr]  = 1'b0;
    if (issue_fire) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // Register array; entry 0 stays at its reset value of zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[rd_addr] <= rd_data_from_wb;
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated scoreboard for the RISC-V core. It provides two combinational read ports, one clocked write-back port with a write-to-read bypass, and hardwired-zero register 0. Per-register busy bits track in-flight destination writes and raise a stall to the issue stage on RAW/WAW hazards. It sits between decode/issue (reads and issue requests) and write-back (rd writes).

## Interface
Parameters:
- XLEN, 32, data width in bits
- AW, 5, register address width; NREGS = 2**AW registers
- BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports and clears hazards; 0 = no forwarding

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_re, rs2_re  in  1  read enables
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- issue_valid  in  1  issue stage presents an instruction this cycle
- issue_rd_we  in  1  issuing instruction writes a destination
- issue_rd  in  AW  destination of issuing instruction
- stall  out  1  issue must hold; instruction not accepted this cycle
- rd_addr  in  AW  write-back address
- rd_we  in  1  write-back enable
- rd_data_from_wb  in  XLEN  write-back data
- busy  out  NREGS  busy bit vector, bit i = register i has a pending write

## Operation
- Storage: NREGS x XLEN array plus NREGS busy flops. Register 0 and busy[0] are constant 0; writes/issues to 0 are ignored.
- Read port n (combinational): rsn_re=0 -> 0; rsn_addr=0 -> 0; BYPASS=1 and rd_we and rd_addr==rsn_addr -> rd_data_from_wb; else array[rsn_addr].
- Write: on posedge clk, rd_we and rd_addr!=0 -> array[rd_addr] <= rd_data_from_wb. rd_we=0 leaves array unchanged (no zeroing).
- Hazard per source n: hzn = rsn_re && rsn_addr!=0 && busy[rsn_addr] && !(BYPASS && rd_we && rd_addr==rsn_addr).
- WAW: hzw = issue_rd_we && issue_rd!=0 && busy[issue_rd] && !(BYPASS && rd_we && rd_addr==issue_rd).
- stall = issue_valid && (hz1 || hz2 || hzw). stall=0 whenever issue_valid=0.
- issue_fire = issue_valid && !stall && issue_rd_we && issue_rd!=0.
- Busy update on posedge clk: rd_we && rd_addr!=0 clears busy[rd_addr]; issue_fire sets busy[issue_rd]. Same address both: set wins (busy stays 1).
- Write-back to a non-busy register is legal: array written, busy unchanged.
- Reset mid-operation: all pending writes discarded, busy=0, array=0; a write-back arriving in the reset-release cycle is ignored if reset is still high at the edge.

## Timing
- Reset values: array all 0, busy = 0, rs1_data/rs2_data = 0 unless bypass path active, stall = 0 unless hazard on current inputs (busy=0, so stall=0 during reset).
- Read latency 0 (combinational from address/enable, array, bypass).
- Write latency 1: data written at edge N visible from array in cycle N+1; with BYPASS=1 visible in cycle N via bypass.
- Busy set at edge where issue_fire; visible on busy and stall from next cycle.
- stall combinational from inputs and busy; no registered handshake. Issue holds inputs while stall=1.
- BYPASS=0: reading a register being written in the same cycle returns old value and stalls if busy.

## Test plan
- Reset: assert reset async mid-cycle after writing x5=0xDEADBEEF -> rs1_addr=5 reads 0, busy=0, stall=0 immediately.
- Write/read + x0: write x7=0x12345678, then rs1_addr=7 -> 0x12345678; write x0=0xFFFFFFFF -> x0 reads 0, busy[0]=0.
- Bypass: BYPASS=1, rd_we=1 rd_addr=3 data 0xA5A5A5A5, rs2_addr=3 same cycle -> rs2_data=0xA5A5A5A5; BYPASS=0 -> old value 0.
- RAW stall: issue rd=9 (busy[9]=1 next cycle); issue reading rs1=9 -> stall=1 for each cycle until write-back of x9=0x55; in write-back cycle with BYPASS=1 stall=0 and rs1_data=0x55.
- WAW and simultaneous set/clear: busy[4]=1, issue rd=4 -> stall=1; write-back x4 and issue rd=4 same cycle (BYPASS=1) -> stall=0, busy[4] remains 1 after edge.
- Parameter sweep: XLEN=64, AW=4 -> 16 registers, write x15=0xFFFF_0000_FFFF_0000 reads back exactly; busy width 16.
